// File: rtl/inst_fetch.sv
// Instruction-fetch reader: takes a PC from the PC stage, checks its alignment and range,
// reads the word from instruction memory and holds it for decode.
module inst_fetch #(
    parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          AW          = 10,
    parameter int          TIMEOUT     = 15
) (
    input  logic          if_clk,
    input  logic          rst_n,
    input  logic          if_ena,
    input  logic          flush,
    input  logic          fetch_valid,
    output logic          fetch_ready,
    input  logic [31:0]   pc_addr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    output logic [1:0]    inst_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // 33-bit bounds so a window ending at 4 GiB cannot wrap around.
    localparam logic [32:0] LO_BOUND = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_BOUND = LO_BOUND + 33'(DEPTH_WORDS) * 33'd4;

    logic [1:0]    r_state;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;
    logic          r_inst_valid;
    logic [31:0]   r_inst;
    logic [31:0]   r_inst_pc;
    logic [1:0]    r_inst_err;
    logic [7:0]    r_cnt;

    logic          w_accept;
    logic          w_in_range;
    logic          w_timeout;

    assign fetch_ready = (r_state == S_IDLE) & if_ena & ~flush;
    assign w_accept    = fetch_valid & fetch_ready;
    assign w_in_range  = ({1'b0, pc_addr} >= LO_BOUND) && ({1'b0, pc_addr} < HI_BOUND);
    assign w_timeout   = (r_cnt == 8'(TIMEOUT - 1));

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_err   = r_inst_err;

    // NOTE: reset is sampled on the clock edge like any other input, and all state uses <=
    // so every register sees the pre-edge values of its neighbours.
    always_ff @(posedge if_clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_inst_err   <= ERR_OK;
            r_cnt        <= 8'd0;
        end else if (if_ena) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_inst_pc <= pc_addr;
                        if (pc_addr[1:0] != 2'b00) begin
                            r_inst       <= 32'h0;
                            r_inst_err   <= ERR_ALIGN;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end else if (!w_in_range) begin
                            r_inst       <= 32'h0;
                            r_inst_err   <= ERR_RANGE;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end else begin
                            r_mem_addr <= AW'((pc_addr - BASE_ADDR) >> 2);
                            r_cnt      <= 8'd0;
                            r_mem_req  <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_inst       <= mem_rdata;
                            r_inst_err   <= ERR_OK;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end else if (w_timeout) begin
                        // A flush arriving on the timeout cycle just discards the error.
                        r_mem_req <= 1'b0;
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_inst       <= 32'h0;
                            r_inst_err   <= ERR_TIMEOUT;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (flush) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Keep requesting until memory answers or gives up; the word is dropped.
                    if (mem_ack || w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    if (flush || inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
